// File: rtl/vc_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_buffer_pkg
// Description : Shared helpers for the multi-channel packet buffer.
//               - clog2-based width helpers (channel-select width, pointer
//                 width including the wrap bit)
//               - ptr_t pointer type for the default channel depth
//               - usedw slice-offset helper for the packed occupancy bus
// Revision    : 1.0 - initial release
// ============================================================================
package vc_buffer_pkg;

    localparam int c_DEF_DEPTH_LOG = 3;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Pointer width: address bits plus the wrap bit that separates
    // full from empty when the address bits match.
    function automatic int ptr_width(input int depth_log);
        return depth_log + 1;
    endfunction

    typedef logic [c_DEF_DEPTH_LOG:0] ptr_t;

    // LSB of channel vc's field inside the packed usedw bus.
    function automatic int usedw_lsb(input int vc, input int depth_log);
        return vc * ptr_width(depth_log);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_buffer_ptr.sv
`default_nettype none
// ============================================================================
// Module      : vc_buffer_ptr
// Description : Head/tail pointer pair for one virtual channel, with full,
//               empty, occupancy and sticky error flags.
//               Ports: clk, rst; i_wr_req / i_rd_req (request already
//               decoded for this channel); o_wr_acc / o_rd_acc (accepted
//               operations); o_head_addr / o_tail_addr (storage offsets);
//               o_full, o_empty, o_usedw; o_err_overflow, o_err_underflow.
//               Error flags are built only when VC_BUFFER_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_buffer_ptr
    import vc_buffer_pkg::*;
#(
    parameter int DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_req,
    input  logic                 i_rd_req,
    output logic                 o_wr_acc,
    output logic                 o_rd_acc,
    output logic [DEPTH_LOG-1:0] o_head_addr,
    output logic [DEPTH_LOG-1:0] o_tail_addr,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [DEPTH_LOG:0]   o_usedw,
    output logic                 o_err_overflow,
    output logic                 o_err_underflow
);

    localparam int c_PTR_W = ptr_width(DEPTH_LOG);

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;

    // Status derives only from registered pointers, so acceptance is judged
    // against the pre-edge state for both operations independently.
    assign o_empty = (r_head == r_tail);
    assign o_full  = (r_head[DEPTH_LOG-1:0] == r_tail[DEPTH_LOG-1:0]) &&
                     (r_head[DEPTH_LOG] != r_tail[DEPTH_LOG]);
    assign o_usedw = r_tail - r_head;

    assign o_wr_acc = i_wr_req && !o_full;
    assign o_rd_acc = i_rd_req && !o_empty;

    assign o_head_addr = r_head[DEPTH_LOG-1:0];
    assign o_tail_addr = r_tail[DEPTH_LOG-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (o_wr_acc) r_tail <= r_tail + 1'b1;
            if (o_rd_acc) r_head <= r_head + 1'b1;
        end
    end

`ifdef VC_BUFFER_ERR_EN
    logic r_err_overflow;
    logic r_err_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (i_wr_req && o_full)  r_err_overflow  <= 1'b1;
            if (i_rd_req && o_empty) r_err_underflow <= 1'b1;
        end
    end

    assign o_err_overflow  = r_err_overflow;
    assign o_err_underflow = r_err_underflow;
`else
    assign o_err_overflow  = 1'b0;
    assign o_err_underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vc_buffer
// Description : NUM_VC independent show-ahead FIFOs sharing one storage
//               array (channel v owns entries v*DEPTH .. v*DEPTH+DEPTH-1).
//               Ports: clk, rst; wr_en/wr_vc/wr_data write side;
//               rd_en/rd_vc read side with combinational rd_data (head of
//               rd_vc); per-channel full, empty, packed usedw; registered
//               credit_valid/credit_vc; sticky err_overflow/err_underflow.
//               Optional macro VC_BUFFER_ERR_EN builds the error flags;
//               otherwise they are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_buffer
    import vc_buffer_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int DEPTH_LOG = 3,
    parameter int WIDTH     = 64,
    parameter int VC_LOG    = clog2_min1(NUM_VC)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [VC_LOG-1:0]               wr_vc,
    input  logic [WIDTH-1:0]                wr_data,
    input  logic                            rd_en,
    input  logic [VC_LOG-1:0]               rd_vc,
    output logic [WIDTH-1:0]                rd_data,
    output logic [NUM_VC-1:0]               full,
    output logic [NUM_VC-1:0]               empty,
    output logic [NUM_VC*(DEPTH_LOG+1)-1:0] usedw,
    output logic                            credit_valid,
    output logic [VC_LOG-1:0]               credit_vc,
    output logic [NUM_VC-1:0]               err_overflow,
    output logic [NUM_VC-1:0]               err_underflow
);

    localparam int c_DEPTH   = 2 ** DEPTH_LOG;
    localparam int c_ENTRIES = NUM_VC * c_DEPTH;

    logic [WIDTH-1:0]     r_mem [c_ENTRIES];

    logic [NUM_VC-1:0]    w_wr_req;
    logic [NUM_VC-1:0]    w_rd_req;
    logic [NUM_VC-1:0]    w_wr_acc;
    logic [NUM_VC-1:0]    w_rd_acc;
    logic [DEPTH_LOG-1:0] w_head [NUM_VC];
    logic [DEPTH_LOG-1:0] w_tail [NUM_VC];
    logic [DEPTH_LOG-1:0] w_wr_tail;
    logic [DEPTH_LOG-1:0] w_rd_head;

    logic                 r_credit_valid;
    logic [VC_LOG-1:0]    r_credit_vc;

    // Out-of-range channel numbers decode to no channel, so such requests
    // neither move pointers nor raise error flags.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_wr_req[v] = wr_en && (wr_vc == VC_LOG'(v));
        assign w_rd_req[v] = rd_en && (rd_vc == VC_LOG'(v));

        vc_buffer_ptr #(
            .DEPTH_LOG (DEPTH_LOG)
        ) u_ptr (
            .clk             (clk),
            .rst             (rst),
            .i_wr_req        (w_wr_req[v]),
            .i_rd_req        (w_rd_req[v]),
            .o_wr_acc        (w_wr_acc[v]),
            .o_rd_acc        (w_rd_acc[v]),
            .o_head_addr     (w_head[v]),
            .o_tail_addr     (w_tail[v]),
            .o_full          (full[v]),
            .o_empty         (empty[v]),
            .o_usedw         (usedw[usedw_lsb(v, DEPTH_LOG) +: DEPTH_LOG+1]),
            .o_err_overflow  (err_overflow[v]),
            .o_err_underflow (err_underflow[v])
        );
    end

    always_comb begin
        w_wr_tail = '0;
        w_rd_head = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_vc == VC_LOG'(v)) w_wr_tail = w_tail[v];
            if (rd_vc == VC_LOG'(v)) w_rd_head = w_head[v];
        end
    end

    // Channel number forms the upper address bits, giving each channel its
    // own contiguous DEPTH-entry region. Storage is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && (|w_wr_acc)) begin
            r_mem[{wr_vc, w_wr_tail}] <= wr_data;
        end
    end

    assign rd_data = r_mem[{rd_vc, w_rd_head}];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit_valid <= 1'b0;
            r_credit_vc    <= '0;
        end else begin
            r_credit_valid <= |w_rd_acc;
            if (|w_rd_acc) r_credit_vc <= rd_vc;
        end
    end

    assign credit_valid = r_credit_valid;
    assign credit_vc    = r_credit_vc;

endmodule
`default_nettype wire
